// File: rtl/ex_mem_buffer_pkg.sv
// Shared widths and state encoding for the EX/MEM pipeline buffer.
package ex_mem_buffer_pkg;

   localparam int unsigned DATA_BUS_WIDTH     = 32;
   localparam int unsigned REG_ADDR_BUS_WIDTH = 5;

   // The encoding equals the number of held entries, so it doubles as occupancy.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StHalf  = 2'd1,
      StFull  = 2'd2
   } buf_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload slot {result, write_reg_en, write_reg_addr}: load-enabled, synchronous clear.
module pipe_entry_reg #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] result_d,
   input  logic                  wen_d,
   input  logic [ADDR_WIDTH-1:0] waddr_d,
   output logic [DATA_WIDTH-1:0] result_q,
   output logic                  wen_q,
   output logic [ADDR_WIDTH-1:0] waddr_q
);

   // Clear wins over load so a flush never lets a same-cycle entry slip in.
   always_ff @(posedge clk) begin
      if (clr) begin
         result_q <= '0;
         wen_q    <= 1'b0;
         waddr_q  <= '0;
      end else if (load) begin
         result_q <= result_d;
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
      end
   end

endmodule

// File: rtl/ex_mem_buffer.sv
// EX/MEM pipeline buffer: two-entry skid buffer (SKID=1) or single register (SKID=0).
module ex_mem_buffer
   import ex_mem_buffer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_BUS_WIDTH,
   parameter int unsigned ADDR_WIDTH = REG_ADDR_BUS_WIDTH,
   parameter int unsigned SKID       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] result_in,
   input  logic                  write_reg_en_in,
   input  logic [ADDR_WIDTH-1:0] write_reg_addr_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result_out,
   output logic                  write_reg_en_out,
   output logic [ADDR_WIDTH-1:0] write_reg_addr_out,
   output logic [1:0]            occupancy
);

   logic [DATA_WIDTH-1:0] head_result;
   logic                  head_wen;
   logic [ADDR_WIDTH-1:0] head_waddr;
   logic                  valid_int;
   logic                  ready_int;
   logic [1:0]            occ_int;
   logic                  entry_clr;

   assign entry_clr = rst | flush;

   if (SKID != 0) begin : g_skid
      buf_state_e            state_q, state_d;
      logic                  rdy_q;
      logic                  in_fire, out_fire;
      logic                  head_load, skid_load, head_from_skid;
      logic [DATA_WIDTH-1:0] skid_result, head_result_d;
      logic                  skid_wen, head_wen_d;
      logic [ADDR_WIDTH-1:0] skid_waddr, head_waddr_d;

      assign in_fire  = in_valid & rdy_q;
      assign out_fire = (state_q != StEmpty) & out_ready;

      // Next state and slot load controls; flush empties regardless of fires.
      always_comb begin
         state_d        = state_q;
         head_load      = 1'b0;
         skid_load      = 1'b0;
         head_from_skid = 1'b0;
         if (!flush) begin
            case (state_q)
               StEmpty: begin
                  if (in_fire) begin
                     state_d   = StHalf;
                     head_load = 1'b1;
                  end
               end
               StHalf: begin
                  case ({in_fire, out_fire})
                     2'b10: begin
                        state_d   = StFull;
                        skid_load = 1'b1;
                     end
                     2'b01: state_d = StEmpty;
                     2'b11: head_load = 1'b1;
                     default: ;
                  endcase
               end
               StFull: begin
                  if (out_fire) begin
                     state_d        = StHalf;
                     head_load      = 1'b1;
                     head_from_skid = 1'b1;
                  end
               end
               default: state_d = StEmpty;
            endcase
         end else begin
            state_d = StEmpty;
         end
      end

      // State register; in_ready is registered to cut the out_ready -> in_ready path.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= StEmpty;
            rdy_q   <= 1'b1;
         end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != StFull);
         end
      end

      assign head_result_d = head_from_skid ? skid_result : result_in;
      assign head_wen_d    = head_from_skid ? skid_wen    : write_reg_en_in;
      assign head_waddr_d  = head_from_skid ? skid_waddr  : write_reg_addr_in;

      pipe_entry_reg #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_head (
         .clk      (clk),
         .clr      (entry_clr),
         .load     (head_load),
         .result_d (head_result_d),
         .wen_d    (head_wen_d),
         .waddr_d  (head_waddr_d),
         .result_q (head_result),
         .wen_q    (head_wen),
         .waddr_q  (head_waddr)
      );

      pipe_entry_reg #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_skid (
         .clk      (clk),
         .clr      (entry_clr),
         .load     (skid_load),
         .result_d (result_in),
         .wen_d    (write_reg_en_in),
         .waddr_d  (write_reg_addr_in),
         .result_q (skid_result),
         .wen_q    (skid_wen),
         .waddr_q  (skid_waddr)
      );

      assign ready_int = rdy_q;
      assign valid_int = (state_q != StEmpty);
      assign occ_int   = state_q;
   end else begin : g_single
      logic valid_q, valid_d;
      logic in_fire, out_fire;

      assign ready_int = ~valid_q | out_ready;
      assign in_fire   = in_valid & ready_int;
      assign out_fire  = valid_q & out_ready;

      // Occupancy flag next state; flush drops the held and any offered entry.
      always_comb begin
         valid_d = valid_q;
         if (flush) begin
            valid_d = 1'b0;
         end else if (in_fire) begin
            valid_d = 1'b1;
         end else if (out_fire) begin
            valid_d = 1'b0;
         end
      end

      // Occupancy flag register.
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
         end else begin
            valid_q <= valid_d;
         end
      end

      pipe_entry_reg #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_head (
         .clk      (clk),
         .clr      (entry_clr),
         .load     (in_fire),
         .result_d (result_in),
         .wen_d    (write_reg_en_in),
         .waddr_d  (write_reg_addr_in),
         .result_q (head_result),
         .wen_q    (head_wen),
         .waddr_q  (head_waddr)
      );

      assign valid_int = valid_q;
      assign occ_int   = {1'b0, valid_q};
   end

   // Data outputs read zero whenever nothing is valid; the head slot may hold stale data.
   always_comb begin
      in_ready           = ready_int;
      out_valid          = valid_int;
      occupancy          = occ_int;
      result_out         = valid_int ? head_result : '0;
      write_reg_en_out   = valid_int & head_wen;
      write_reg_addr_out = valid_int ? head_waddr : '0;
   end

endmodule
